// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings, FSM state, command record and alignment check for mem_arbiter.
package mem_arb_pkg;
  localparam logic [1:0] BH_BYTE = 2'b01;
  localparam logic [1:0] BH_HALF = 2'b10;
  localparam logic [1:0] BH_WORD = 2'b00;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef struct packed {
    logic        we;
    logic        sign;
    logic [1:0]  bhop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        port;
  } cmd_t;
  function automatic logic misaligned(input logic [1:0] bhop, input logic [1:0] a);
    return bhop == BH_BYTE ? 1'b0 : bhop == BH_HALF ? a[0] : a != 2'b00;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant between two requesters, round-robin or port-0 priority on ties.
module rr_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  always_comb gnt = req0 && req1 ? ((FIXED_PRIO != 0 || last_grant) ? 2'b01 : 2'b10) : {req1, req0};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a combinational-read memory, one access per two cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic        sign0,
  input  logic [1:0]  bhop0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic        sign1,
  input  logic [1:0]  bhop1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        WE,
  output logic        signM,
  output logic [1:0]  Byte_Half_OpM,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD
);
  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        last_q, last_d;
  logic [1:0]  rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]  arb;
  logic        err;
  rr_arbiter #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req0      (req0),
    .req1      (req1),
    .last_grant(last_q),
    .gnt       (arb)
  );
  // grants are gated by reset so none is seen before the cycle after deassertion
  always_comb begin
    gnt0 = state_q == IDLE && !reset && arb[0];
    gnt1 = state_q == IDLE && !reset && arb[1];
    err = misaligned(cmd_q.bhop, cmd_q.addr[1:0]);
    state_d = gnt0 || gnt1 ? ACCESS : IDLE;
    last_d = gnt0 || gnt1 ? gnt1 : last_q;
    cmd_d = gnt1 ? {we1, sign1, bhop1, addr1, wdata1, 1'b1} :
            gnt0 ? {we0, sign0, bhop0, addr0, wdata0, 1'b0} : cmd_q;
    rvalid_d = state_q == ACCESS ? (cmd_q.port ? 2'b10 : 2'b01) : 2'b00;
    err_d = err ? rvalid_d : 2'b00;
    rdata0_d = rvalid_d[0] ? (err || cmd_q.we ? 32'h0 : RD) : rdata0_q;
    rdata1_d = rvalid_d[1] ? (err || cmd_q.we ? 32'h0 : RD) : rdata1_q;
    WE = state_q == ACCESS && cmd_q.we && !err;
    signM = cmd_q.sign;
    Byte_Half_OpM = cmd_q.bhop;
    A = cmd_q.addr;
    WD = cmd_q.wdata;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      last_q <= 1'b1;
      rvalid_q <= 2'b00;
      err_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      last_q <= last_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0 = err_q[0];
  assign err1 = err_q[1];
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin between ports, 1 = port 0 (core LSU) always wins.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Ports, clock and reset first:
- CLK  in  1  clock.
- reset  in  1  async active-high reset.
REQ-004 Per requester port p in {0,1}, upstream side:
- reqP  in  1  request valid.
- weP  in  1  1 = store.
- signP  in  1  1 = signed load.
- bhopP  in  2  size: 01 = byte, 10 = half, other = word.
REQ-005 Per requester port p in {0,1}, address, data and response:
- addrP  in  32  byte address.
- wdataP  in  32  store data.
- gntP  out  1  request accepted this cycle.
- rvalidP  out  1  response pulse.
- rdataP  out  32  load data.
- errP  out  1  misaligned-access flag, valid with rvalidP.
REQ-006 Memory side:
- WE  out  1  write enable.
- signM  out  1  signed load.
- Byte_Half_OpM  out  2  access size.
- A  out  32  address.
- WD  out  32  write data.
- RD  in  32  combinational read data.

Function
REQ-007 FSM states IDLE and ACCESS; reset state IDLE.
REQ-008 IDLE, any reqP high: arbitrate and assert gntP combinationally for exactly one port; on the clock edge capture that port's command and port ID into a command register and go to ACCESS.
REQ-009 Arbitration, FIXED_PRIO=0: on simultaneous requests, grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
REQ-010 Arbitration, FIXED_PRIO=1: port 0 wins every tie.
REQ-011 ACCESS: drive A, WD, signM and Byte_Half_OpM from the command register; capture RD into the response register at the end of the cycle; always return to IDLE next.
REQ-012 WE is high only in ACCESS, for a store with err=0; it is 0 in every other cycle.
REQ-013 In IDLE, memory outputs hold the last command register value and WE=0.
REQ-014 Misalignment: err=1 when a half access has A[0]=1, or a word access has A[1:0]!=00; byte accesses never err.
REQ-015 On err=1: suppress WE and force rdata=0.
REQ-016 Response timing: rvalidP pulses for one cycle, the cycle after ACCESS, only on the port that was granted; rdataP and errP are valid only in that cycle.
REQ-017 Stores also produce a response pulse, with rdata=0.
REQ-018 Latency: gnt at cycle N, memory access at N+1, rvalid at N+2; a new grant may coincide with rvalid, giving a maximum throughput of one access per 2 cycles.
REQ-019 gntP is never asserted in ACCESS; requesters hold reqP and the command stable until gntP is seen.
REQ-020 A request dropped before its grant is discarded with no response.
REQ-021 rdataP holds its value between responses.
REQ-022 Output reset values: gnt0/1=0, rvalid0/1=0, err0/1=0, rdata0/1=0, WE=0, A=0, WD=0, signM=0, Byte_Half_OpM=00.

Reset
REQ-023 Asynchronous reset clears the FSM, command register, response registers and last_grant (to 1).
REQ-024 Reset asserted during ACCESS aborts the access: WE drops immediately and no rvalid is generated for that access.
REQ-025 Deassertion is synchronized externally; the first possible grant is in the cycle after deassertion.

Structure
REQ-026 Package mem_arb_pkg holds:
- size encodings BH_BYTE=2'b01, BH_HALF=2'b10, BH_WORD=2'b00;
- the state enum {IDLE, ACCESS};
- the command struct {we, sign, bhop, addr, wdata, port}.
REQ-027 One sub-module, rr_arbiter, takes two requests plus last_grant and FIXED_PRIO and outputs a one-hot grant.
REQ-028 The memory is not instantiated inside mem_arbiter.

Verification
REQ-029 Port 0 alone, word store 0xDEADBEEF to 0x100, then word load from 0x100 -> WE high one cycle at N+1; load rvalid0 at N+2 with rdata0=0xDEADBEEF, err0=0.
REQ-030 Both ports request every cycle, FIXED_PRIO=0 -> grants alternate 0,1,0,1; no grant in ACCESS cycles; each rvalid lands on the port granted 2 cycles earlier.
REQ-031 Both ports request, FIXED_PRIO=1 -> only port 0 is granted while req0 stays high; port 1 is granted on the first idle cycle after req0 drops.
REQ-032 Port 1 half store to 0x203 -> err1=1 with rvalid1, WE never high, memory at 0x202/0x203 unchanged.
REQ-033 Byte load, sign=1, from an address holding 0x80 -> rdata=0xFFFFFF80; same load with sign=0 -> rdata=0x00000080.
REQ-034 Reset asserted during the ACCESS of a store -> WE falls asynchronously, no rvalid follows, and all outputs return to reset values.
